instr_sequencer: RTL and testbench
==================================

Name: instr_sequencer

Overview:
- Parametrised coprocessor instruction player: holds a loadable program of INSTR_W-bit coprocessor instructions and issues them in order to the coprocessor top level.
- Successor to the fixed-ROM, button-stepped test driver; adds a loadable program, step/run/loop modes, a valid/ready issue handshake with done-wait, and halt-on-opcode.
- Sits between the board-level debounced controls (or a host loader) and the coprocessor instruction input.

Parameters:
- INSTR_W, 22, instruction width; opcode is bits [3:0].
- DEPTH, 32, program slots.
- ADDR_W, 5, address width; DEPTH <= 2**ADDR_W.
- HALT_OP, 4'b0000, opcode that terminates run/loop without issuing.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- prog_we  in  1  program write strobe.
- prog_addr  in  ADDR_W  program write address.
- prog_data  in  INSTR_W  program write data.
- prog_len  in  ADDR_W+1  number of valid slots (0..DEPTH); sampled at start/step launch.
- mode  in  2  00 step, 01 run, 10 loop, 11 reserved (treated as run).
- start  in  1  level, internally edge-detected; launches run/loop from slot 0.
- step  in  1  level, internally edge-detected; issues next slot in step mode.
- abort  in  1  return to IDLE immediately.
- instr_out  out  INSTR_W  instruction to coprocessor.
- instr_valid  out  1  instr_out valid.
- instr_ready  in  1  coprocessor accepts instr_out.
- cp_done  in  1  coprocessor finished the accepted instruction (1-cycle pulse).
- pc  out  ADDR_W  slot currently being or next to be issued.
- busy  out  1  high in FETCH/ISSUE/WAIT.
- halted  out  1  high in DONE.
- issued_cnt  out  16  instructions accepted since last start; saturates at 16'hFFFF.

Behaviour:
- Reset: instr_out=0, instr_valid=0, pc=0, busy=0, halted=0, issued_cnt=0, state IDLE, edge-detect registers cleared, program memory contents undefined.
- Edge detection: start_rise/step_rise = input high AND previous-cycle sample low.
- Program memory: synchronous write on prog_we, accepted only in IDLE or DONE; otherwise ignored. Synchronous read, 1-cycle latency.
- States:
  - IDLE: start_rise (mode != 00) sets pc=0, clears issued_cnt, goes to FETCH. step_rise (mode 00) goes to FETCH at the current pc. If both rise in the same cycle, start wins.
  - FETCH: one cycle for the memory read; read data is registered into instr_out. If opcode == HALT_OP, go to DONE with no issue. Otherwise go to ISSUE.
  - ISSUE: instr_valid=1 and instr_out held stable until instr_ready. On the cycle instr_valid && instr_ready: instr_valid drops next cycle, issued_cnt increments, go to WAIT.
  - WAIT: on cp_done, pc advances. If mode 01 and pc+1 == prog_len, go to DONE. If mode 10 and pc+1 == prog_len, pc wraps to 0 and goes to FETCH. If mode 00, go to IDLE; at the end of the program, pc wraps to 0. Otherwise go to FETCH.
  - DONE: halted=1, pc holds. start_rise restarts as in IDLE. step_rise is ignored. A mode change has no effect until the next start.
- cp_done arriving in the same cycle as acceptance is ignored; it is only valid in WAIT.
- prog_len == 0: start goes directly to DONE, and no instruction is issued.
- Edges of start/step while busy are ignored; they are not queued.
- abort (any state): next cycle state=IDLE, instr_valid=0, pc=0. issued_cnt and program contents are retained. abort has priority over all other inputs. rst has priority over abort.
- Throughput: minimum 3 cycles per instruction (FETCH, ISSUE with ready=1, WAIT with cp_done the same cycle as entry).

Test Plan:
- Load slots 0..2 = 22'h000082, 22'h000102, 22'h000003; prog_len=3; mode=01; start pulse, ready=1, cp_done 2 cycles after each accept -> three issues in order, issued_cnt=3, halted=1, pc=2.
- Same program, mode=00; three step pulses each held 10 cycles -> one issue per rising edge; held level causes no repeat; after the 3rd, pc=0 and state IDLE.
- mode=10, prog_len=2, run 6 instructions, then abort -> issue order 0,1,0,1,0,1; after abort instr_valid=0, pc=0, issued_cnt=6.
- Hold instr_ready=0 for 20 cycles in ISSUE -> instr_valid stays 1 with instr_out stable; a step_rise during this time is ignored; on ready=1, exactly one accept.
- Slot 1 = opcode 0000, prog_len=4, mode=01 -> only slot 0 issued, DONE with pc=1; prog_we during ISSUE leaves memory unchanged, verified by re-read on restart.
- prog_len=0 with start -> DONE next-but-one cycle, instr_valid never asserted; rst asserted mid-WAIT -> all outputs at reset values the next cycle.

Source files
------------

// File: rtl/instr_sequencer.sv
// instr_sequencer: loadable coprocessor instruction player.
// Holds a small program in synchronous memory and issues it slot by slot to
// the coprocessor in step, run or loop mode, waiting for cp_done after every
// accepted instruction. A slot whose opcode equals HALT_OP ends run/loop
// without being issued.
//
// Issue handshake: o_instr_valid rises with o_instr_out already stable, and
// both hold unchanged until the cycle where o_instr_valid && i_instr_ready;
// that cycle is the single acceptance, and o_instr_valid drops on the next
// cycle. i_cp_done is only honoured after acceptance, in WAIT.
module instr_sequencer #(
    parameter int         INSTR_W = 22,
    parameter int         DEPTH   = 32,
    parameter int         ADDR_W  = 5,
    parameter logic [3:0] HALT_OP = 4'b0000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_prog_we,
    input  logic [ADDR_W-1:0]  i_prog_addr,
    input  logic [INSTR_W-1:0] i_prog_data,
    input  logic [ADDR_W:0]    i_prog_len,
    input  logic [1:0]         i_mode,
    input  logic               i_start,
    input  logic               i_step,
    input  logic               i_abort,
    output logic [INSTR_W-1:0] o_instr_out,
    output logic               o_instr_valid,
    input  logic               i_instr_ready,
    input  logic               i_cp_done,
    output logic [ADDR_W-1:0]  o_pc,
    output logic               o_busy,
    output logic               o_halted,
    output logic [15:0]        o_issued_cnt,
    output logic [2:0]         o_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_ISSUE = 3'd2,
        S_WAIT  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [1:0] MODE_STEP = 2'b00;
    localparam logic [1:0] MODE_RUN  = 2'b01;
    localparam logic [1:0] MODE_LOOP = 2'b10;

    state_t             r_state;
    logic [INSTR_W-1:0] r_mem [DEPTH];
    logic               r_start_q;
    logic               r_step_q;
    logic [1:0]         r_mode;      // mode latched at launch; later mode changes wait for the next start
    logic [ADDR_W:0]    r_len;       // program length latched at launch
    logic [ADDR_W-1:0]  r_pc;
    logic [INSTR_W-1:0] r_instr;
    logic               r_valid;
    logic               r_busy;
    logic               r_halted;
    logic [15:0]        r_cnt;

    logic               w_start_rise;
    logic               w_step_rise;
    logic               w_launch_run;
    logic               w_launch_step;
    logic               w_last;
    logic               w_prog_open;
    logic               w_is_halt;
    logic [INSTR_W-1:0] w_rd_data;
    logic [ADDR_W-1:0]  w_pc_inc;

    assign w_start_rise  = i_start & ~r_start_q;
    assign w_step_rise   = i_step & ~r_step_q;
    // Reserved mode 11 launches like run.
    assign w_launch_run  = w_start_rise && (i_mode != MODE_STEP);
    assign w_launch_step = w_step_rise && (i_mode == MODE_STEP);
    assign w_pc_inc      = r_pc + {{(ADDR_W-1){1'b0}}, 1'b1};
    assign w_last        = ({1'b0, r_pc} + {{ADDR_W{1'b0}}, 1'b1}) == r_len;
    assign w_prog_open   = (r_state == S_IDLE) || (r_state == S_DONE);
    assign w_rd_data     = r_mem[r_pc];
    assign w_is_halt     = (w_rd_data[3:0] == HALT_OP);

    assign o_instr_out   = r_instr;
    assign o_instr_valid = r_valid;
    assign o_pc          = r_pc;
    assign o_busy        = r_busy;
    assign o_halted      = r_halted;
    assign o_issued_cnt  = r_cnt;
    assign o_state       = r_state;

    // Program memory write port; loads are only taken while nothing is in flight.
    always_ff @(posedge clk) begin
        if (i_prog_we && w_prog_open) begin
            r_mem[i_prog_addr] <= i_prog_data;
        end
    end

    // Previous-cycle samples of start/step for rising-edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_start_q <= 1'b0;
            r_step_q  <= 1'b0;
        end else begin
            r_start_q <= i_start;
            r_step_q  <= i_step;
        end
    end

    // Sequencer FSM with registered outputs; abort outranks everything but reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_mode   <= MODE_STEP;
            r_len    <= '0;
            r_pc     <= '0;
            r_instr  <= '0;
            r_valid  <= 1'b0;
            r_busy   <= 1'b0;
            r_halted <= 1'b0;
            r_cnt    <= '0;
        end else if (i_abort) begin
            r_state  <= S_IDLE;
            r_pc     <= '0;
            r_valid  <= 1'b0;
            r_busy   <= 1'b0;
            r_halted <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_launch_run) begin
                        r_pc   <= '0;
                        r_cnt  <= '0;
                        r_len  <= i_prog_len;
                        r_mode <= (i_mode == MODE_LOOP) ? MODE_LOOP : MODE_RUN;
                        if (i_prog_len == '0) begin
                            r_state  <= S_DONE;
                            r_busy   <= 1'b0;
                            r_halted <= 1'b1;
                        end else begin
                            r_state  <= S_FETCH;
                            r_busy   <= 1'b1;
                            r_halted <= 1'b0;
                        end
                    end else if ((r_state == S_IDLE) && w_launch_step && (i_prog_len != '0)) begin
                        // Step issues the slot at the current pc; an empty program has nothing to step.
                        r_len   <= i_prog_len;
                        r_mode  <= MODE_STEP;
                        r_state <= S_FETCH;
                        r_busy  <= 1'b1;
                    end
                end
                S_FETCH: begin
                    r_instr <= w_rd_data;
                    if (w_is_halt) begin
                        r_state  <= S_DONE;
                        r_busy   <= 1'b0;
                        r_halted <= 1'b1;
                    end else begin
                        r_state <= S_ISSUE;
                        r_valid <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    if (i_instr_ready) begin
                        r_valid <= 1'b0;
                        r_state <= S_WAIT;
                        if (r_cnt != 16'hFFFF) begin
                            r_cnt <= r_cnt + 16'd1;
                        end
                    end
                end
                S_WAIT: begin
                    if (i_cp_done) begin
                        if ((r_mode == MODE_RUN) && w_last) begin
                            // Run ends with pc parked on the last issued slot.
                            r_state  <= S_DONE;
                            r_busy   <= 1'b0;
                            r_halted <= 1'b1;
                        end else begin
                            r_pc <= w_last ? '0 : w_pc_inc;
                            if (r_mode == MODE_STEP) begin
                                r_state <= S_IDLE;
                                r_busy  <= 1'b0;
                            end else begin
                                r_state <= S_FETCH;
                            end
                        end
                    end
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_valid  <= 1'b0;
                    r_busy   <= 1'b0;
                    r_halted <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed and randomized bench for instr_sequencer. A slot-walk model of the
// program produces the expected issue order; a negedge monitor records every
// accepted instruction and checks valid/data stability while stalled.
module tb_instr_sequencer;

    localparam int INSTR_W = 22;
    localparam int DEPTH   = 32;
    localparam int ADDR_W  = 5;
    localparam int LW      = ADDR_W + 1;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               prog_we = 1'b0;
    logic [ADDR_W-1:0]  prog_addr = '0;
    logic [INSTR_W-1:0] prog_data = '0;
    logic [ADDR_W:0]    prog_len = '0;
    logic [1:0]         mode = 2'b00;
    logic               start = 1'b0;
    logic               step = 1'b0;
    logic               abort = 1'b0;
    logic               instr_ready = 1'b0;
    logic               cp_done = 1'b0;
    logic [INSTR_W-1:0] instr_out;
    logic               instr_valid;
    logic [ADDR_W-1:0]  pc;
    logic               busy;
    logic               halted;
    logic [15:0]        issued_cnt;
    logic [2:0]         dbg_state;

    int checks = 0;
    int failures = 0;

    logic [INSTR_W-1:0] model_mem [DEPTH];
    logic [INSTR_W-1:0] exp_q[$];
    logic [INSTR_W-1:0] got_q[$];
    int                 exp_end_pc = 0;
    bit                 exp_done = 0;

    int rdy_mode = 0;   // 0: ready high, 1: random ready, 2: driven by the test
    int cp_en = 1;
    int cp_dmin = 2;
    int cp_dmax = 2;
    bit valid_seen = 0;

    logic               p_valid = 1'b0;
    logic               p_ready = 1'b0;
    logic               p_hold = 1'b1;
    logic [INSTR_W-1:0] p_out = '0;

    instr_sequencer #(
        .INSTR_W(INSTR_W),
        .DEPTH(DEPTH),
        .ADDR_W(ADDR_W),
        .HALT_OP(4'b0000)
    ) dut (
        .clk(clk),
        .rst(rst),
        .i_prog_we(prog_we),
        .i_prog_addr(prog_addr),
        .i_prog_data(prog_data),
        .i_prog_len(prog_len),
        .i_mode(mode),
        .i_start(start),
        .i_step(step),
        .i_abort(abort),
        .o_instr_out(instr_out),
        .o_instr_valid(instr_valid),
        .i_instr_ready(instr_ready),
        .i_cp_done(cp_done),
        .o_pc(pc),
        .o_busy(busy),
        .o_halted(halted),
        .o_issued_cnt(issued_cnt),
        .o_state(dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Monitor: record accepts, check stall stability
    always @(negedge clk) begin
        if (p_valid && !p_ready && !p_hold) begin
            check("hold_valid", 32'(instr_valid), 32'd1);
            check("hold_data", 32'(instr_out), 32'(p_out));
        end
        if (instr_valid === 1'b1) valid_seen = 1;
        if (instr_valid === 1'b1 && instr_ready === 1'b1) got_q.push_back(instr_out);
        p_valid = (instr_valid === 1'b1);
        p_ready = instr_ready;
        p_out   = instr_out;
        p_hold  = abort || rst;
    end

    // Ready driver
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode == 0) instr_ready = 1'b1;
            else if (rdy_mode == 1) instr_ready = 1'($urandom_range(1, 0));
        end
    end

    // Coprocessor model: cp_done pulse some cycles after each accept
    initial begin
        int d;
        forever begin
            @(negedge clk);
            if (instr_valid === 1'b1 && instr_ready === 1'b1 && cp_en != 0) begin
                d = $urandom_range(cp_dmax, cp_dmin);
                @(posedge clk);
                repeat (d) @(posedge clk);
                #1 cp_done = 1'b1;
                @(posedge clk);
                #1 cp_done = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int a, input logic [INSTR_W-1:0] d, input bit upd);
        tick();
        prog_we = 1'b1;
        prog_addr = a[ADDR_W-1:0];
        prog_data = d;
        tick();
        prog_we = 1'b0;
        if (upd) model_mem[a] = d;
    endtask

    task automatic pulse_start();
        tick();
        start = 1'b1;
        tick();
        tick();
        start = 1'b0;
    endtask

    task automatic do_abort();
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    task automatic wait_halted(input string tag, input int budget);
        int n = 0;
        while (halted !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(halted), 32'd1);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (busy !== 1'b0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(busy), 32'd0);
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int n = 0;
        while (instr_valid !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(instr_valid), 32'd1);
    endtask

    task automatic wait_got(input string tag, input int k, input int budget);
        int n = 0;
        while (got_q.size() < k && n < budget) begin
            @(posedge clk);
            n++;
        end
        check(tag, got_q.size(), k);
    endtask

    // Walk the program as written: slots in order, halt opcode ends the
    // program unissued, run stops after the last slot, loop wraps to slot 0.
    task automatic model_play(input int len, input int md, input int limit);
        int slot = 0;
        exp_q.delete();
        exp_done = 0;
        exp_end_pc = 0;
        if (len == 0) begin
            exp_done = 1;
            return;
        end
        while (exp_q.size() < limit) begin
            if (model_mem[slot][3:0] == 4'h0) begin
                exp_done = 1;
                exp_end_pc = slot;
                return;
            end
            exp_q.push_back(model_mem[slot]);
            exp_end_pc = slot;
            if (slot == len - 1) begin
                if (md != 2) begin
                    exp_done = 1;
                    return;
                end
                slot = 0;
            end else begin
                slot++;
            end
        end
    endtask

    task automatic check_seq(input string tag);
        check({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            check(tag, 32'(got_q[i]), 32'(exp_q[i]));
        end
    endtask

    // Directed and random stimulus
    initial begin
        logic [INSTR_W-1:0] cap;
        logic [INSTR_W-1:0] d;
        bit stable;
        int len;
        int md;
        int lim;
        int n0;

        // Reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_instr_out", 32'(instr_out), 32'd0);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_pc", 32'(pc), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_cnt", 32'(issued_cnt), 32'd0);
        tick();
        rst = 1'b0;

        // Run mode, three slots
        load(0, 22'h000082, 1);
        load(1, 22'h000102, 1);
        load(2, 22'h000003, 1);
        prog_len = LW'(3);
        mode = 2'b01;
        rdy_mode = 0;
        got_q.delete();
        model_play(3, 1, 100);
        pulse_start();
        wait_halted("t1_halt", 200);
        check_seq("t1_seq");
        check("t1_cnt", 32'(issued_cnt), 32'd3);
        check("t1_pc", 32'(pc), 32'd2);
        check("t1_busy", 32'(busy), 32'd0);

        // Step mode: one issue per rising edge, held level does not repeat
        do_abort();
        @(negedge clk);
        check("t2_abort_pc", 32'(pc), 32'd0);
        check("t2_abort_halted", 32'(halted), 32'd0);
        mode = 2'b00;
        got_q.delete();
        for (int k = 0; k < 3; k++) begin
            tick();
            step = 1'b1;
            repeat (10) tick();
            step = 1'b0;
            wait_idle("t2_idle", 50);
            check("t2_steps", got_q.size(), k + 1);
        end
        exp_q.delete();
        for (int i = 0; i < 3; i++) exp_q.push_back(model_mem[i]);
        check_seq("t2_seq");
        check("t2_pc", 32'(pc), 32'd0);
        check("t2_halted", 32'(halted), 32'd0);
        check("t2_cnt", 32'(issued_cnt), 32'd6);

        // Loop mode, two slots, six issues then abort
        prog_len = LW'(2);
        mode = 2'b10;
        cp_dmin = 0;
        cp_dmax = 2;
        got_q.delete();
        model_play(2, 2, 6);
        pulse_start();
        wait_got("t3_got", 6, 300);
        #1 abort = 1'b1;
        tick();
        abort = 1'b0;
        @(negedge clk);
        check("t3_valid", 32'(instr_valid), 32'd0);
        check("t3_pc", 32'(pc), 32'd0);
        check("t3_busy", 32'(busy), 32'd0);
        check("t3_cnt", 32'(issued_cnt), 32'd6);
        check_seq("t3_seq");
        repeat (8) tick();

        // Stall in ISSUE for 20 cycles; step edge while busy is ignored
        prog_len = LW'(3);
        mode = 2'b01;
        rdy_mode = 2;
        tick();
        instr_ready = 1'b0;
        got_q.delete();
        model_play(3, 1, 100);
        pulse_start();
        wait_valid("t4_valid", 20);
        cap = instr_out;
        stable = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!(instr_valid === 1'b1 && instr_out === cap)) stable = 0;
            if (i == 4) mode = 2'b00;
            if (i == 5) step = 1'b1;
            if (i == 10) step = 1'b0;
            if (i == 12) mode = 2'b01;
        end
        check("t4_stable", 32'(stable), 32'd1);
        check("t4_no_accept", got_q.size(), 0);
        check("t4_first_instr", 32'(cap), 32'(model_mem[0]));
        tick();
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        @(negedge clk);
        check("t4_one_accept", got_q.size(), 1);
        check("t4_valid_drop", 32'(instr_valid), 32'd0);
        rdy_mode = 0;
        wait_halted("t4_halt", 200);
        check_seq("t4_seq");
        check("t4_cnt", 32'(issued_cnt), 32'd3);

        // Halt opcode in slot 1; write during ISSUE is ignored
        load(1, 22'h2AB40, 1);
        prog_len = LW'(4);
        mode = 2'b01;
        rdy_mode = 2;
        tick();
        instr_ready = 1'b0;
        got_q.delete();
        model_play(4, 1, 100);
        pulse_start();
        wait_valid("t5_valid", 20);
        load(0, 22'h3FFFF1, 0);
        rdy_mode = 0;
        wait_halted("t5_halt", 200);
        check_seq("t5_seq");
        check("t5_pc", 32'(pc), 32'(exp_end_pc));
        check("t5_cnt", 32'(issued_cnt), 32'd1);
        got_q.delete();
        pulse_start();
        wait_halted("t5_rehalt", 200);
        check_seq("t5_reread");
        check("t5_repc", 32'(pc), 32'd1);

        // Randomized programs, modes, ready and cp_done timing
        rdy_mode = 1;
        cp_dmin = 0;
        cp_dmax = 3;
        for (int it = 0; it < 10; it++) begin
            len = $urandom_range(8, 1);
            md = $urandom_range(3, 1);
            for (int s = 0; s < len; s++) begin
                d = INSTR_W'($urandom);
                if (md == 2 || $urandom_range(7, 0) != 0) begin
                    if (d[3:0] == 4'h0) d[3:0] = 4'h1;
                end else begin
                    d[3:0] = 4'h0;
                end
                load(s, d, 1);
            end
            prog_len = LW'(len);
            mode = 2'(md);
            got_q.delete();
            if (md == 2) begin
                lim = $urandom_range(2 * len + 2, 1);
                model_play(len, 2, lim);
                pulse_start();
                wait_got("rnd_loop_got", lim, 600);
                #1 abort = 1'b1;
                tick();
                abort = 1'b0;
                @(negedge clk);
                check_seq("rnd_loop_seq");
                check("rnd_loop_cnt", 32'(issued_cnt), 32'(lim));
                check("rnd_loop_pc", 32'(pc), 32'd0);
            end else begin
                model_play(len, 1, 1000);
                pulse_start();
                wait_halted("rnd_run_halt", 600);
                check_seq("rnd_run_seq");
                check("rnd_run_pc", 32'(pc), 32'(exp_end_pc));
                check("rnd_run_cnt", 32'(issued_cnt), exp_q.size());
            end
            repeat (8) tick();
        end

        // Empty program: DONE one cycle after the start edge, nothing issued
        do_abort();
        rdy_mode = 0;
        prog_len = '0;
        mode = 2'b01;
        got_q.delete();
        tick();
        valid_seen = 0;
        start = 1'b1;
        @(negedge clk);
        check("t6_not_yet", 32'(halted), 32'd0);
        @(negedge clk);
        check("t6_halted", 32'(halted), 32'd1);
        repeat (4) @(negedge clk);
        check("t6_valid_seen", 32'(valid_seen), 32'd0);
        check("t6_got", got_q.size(), 0);
        check("t6_cnt", 32'(issued_cnt), 32'd0);
        check("t6_busy", 32'(busy), 32'd0);
        tick();
        start = 1'b0;

        // Reset in the middle of WAIT
        load(0, 22'h000082, 1);
        load(1, 22'h000102, 1);
        load(2, 22'h000003, 1);
        prog_len = LW'(3);
        mode = 2'b01;
        cp_en = 0;
        got_q.delete();
        pulse_start();
        wait_got("t7_got", 1, 50);
        repeat (3) tick();
        @(negedge clk);
        check("t7_in_wait", 32'(busy), 32'd1);
        check("t7_cnt_before", 32'(issued_cnt), 32'd1);
        tick();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("t7_instr_out", 32'(instr_out), 32'd0);
        check("t7_valid", 32'(instr_valid), 32'd0);
        check("t7_pc", 32'(pc), 32'd0);
        check("t7_busy", 32'(busy), 32'd0);
        check("t7_halted", 32'(halted), 32'd0);
        check("t7_cnt", 32'(issued_cnt), 32'd0);
        tick();
        rst = 1'b0;
        cp_en = 1;
        repeat (3) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
